// File: rtl/elbeth_fetch_ctrl.sv
// rtl/elbeth_fetch_ctrl.sv - instruction fetch controller with redirect and stall handling
//
// Purpose: fetches one instruction at a time from instruction memory and holds it
// for the decode stage. A redirect takes priority over every other event.
//
// Ports (all 32-bit buses use [0:31] numbering, bit 0 is the MSB):
//   clk          in   clock, rising-edge
//   rst_n        in   asynchronous active-low reset
//   stall        in   decode cannot accept the held instruction
//   redirect     in   branch/jump taken this cycle
//   redirect_pc  in   branch/jump target
//   imem_req     out  instruction memory request
//   imem_addr    out  request address (registered)
//   imem_ack     in   request completes this cycle, imem_rdata valid
//   imem_rdata   in   instruction word
//   if_valid     out  if_pc/if_instr hold a valid instruction
//   if_pc        out  address of the held instruction
//   if_instr     out  held instruction word

module elbeth_fetch_ctrl #(
    parameter logic [0:31] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [0:31] redirect_pc,
    output logic        imem_req,
    output logic [0:31] imem_addr,
    input  logic        imem_ack,
    input  logic [0:31] imem_rdata,
    output logic        if_valid,
    output logic [0:31] if_pc,
    output logic [0:31] if_instr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DELIVER = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    // Loaded PCs are always word aligned (two LSBs, bits [30:31], cleared).
    localparam logic [0:31] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

    state_t      r_state;
    logic [0:31] r_pc;
    logic [0:31] r_req_addr;
    logic        r_if_valid;
    logic [0:31] r_if_pc;
    logic [0:31] r_if_instr;

    state_t      w_state_nxt;
    logic [0:31] w_pc_nxt;
    logic [0:31] w_req_addr_nxt;
    logic        w_if_valid_nxt;
    logic [0:31] w_if_pc_nxt;
    logic [0:31] w_if_instr_nxt;

    logic        w_req;
    logic        w_ack;
    logic [0:31] w_redirect_pc;
    logic [0:31] w_pc_inc;

    // Request is decoded from the state register so an asynchronous reset drops it at once.
    assign w_req         = (r_state == FETCH) || (r_state == FLUSH);
    // An ack outside a request cycle is meaningless and ignored.
    assign w_ack         = imem_ack & w_req;
    assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;
    assign w_pc_inc      = r_pc + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC_ALIGNED;
            r_req_addr <= RESET_PC_ALIGNED;
            r_if_valid <= 1'b0;
            r_if_pc    <= '0;
            r_if_instr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_req_addr <= w_req_addr_nxt;
            r_if_valid <= w_if_valid_nxt;
            r_if_pc    <= w_if_pc_nxt;
            r_if_instr <= w_if_instr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_req_addr_nxt = r_req_addr;
        w_if_valid_nxt = r_if_valid;
        w_if_pc_nxt    = r_if_pc;
        w_if_instr_nxt = r_if_instr;

        case (r_state)
            IDLE: begin
                w_state_nxt = FETCH;
                if (redirect) begin
                    w_pc_nxt       = w_redirect_pc;
                    w_req_addr_nxt = w_redirect_pc;
                    w_if_valid_nxt = 1'b0;
                end else begin
                    w_req_addr_nxt = r_pc;
                end
            end

            FETCH: begin
                if (redirect && w_ack) begin
                    // Returned word belongs to the abandoned path; restart at the target.
                    w_pc_nxt       = w_redirect_pc;
                    w_req_addr_nxt = w_redirect_pc;
                end else if (redirect) begin
                    // The bus transaction cannot be cancelled; drain it in FLUSH.
                    w_pc_nxt    = w_redirect_pc;
                    w_state_nxt = FLUSH;
                end else if (w_ack) begin
                    w_if_instr_nxt = imem_rdata;
                    w_if_pc_nxt    = r_req_addr;
                    w_if_valid_nxt = 1'b1;
                    w_pc_nxt       = w_pc_inc;
                    w_state_nxt    = DELIVER;
                end
            end

            DELIVER: begin
                if (redirect) begin
                    w_pc_nxt       = w_redirect_pc;
                    w_req_addr_nxt = w_redirect_pc;
                    w_if_valid_nxt = 1'b0;
                    w_state_nxt    = FETCH;
                end else if (!stall) begin
                    w_if_valid_nxt = 1'b0;
                    w_req_addr_nxt = r_pc;
                    w_state_nxt    = FETCH;
                end
            end

            FLUSH: begin
                if (redirect) begin
                    w_pc_nxt = w_redirect_pc;
                end
                if (w_ack) begin
                    // A redirect arriving with the ack must still win over the older target.
                    w_req_addr_nxt = redirect ? w_redirect_pc : r_pc;
                    w_state_nxt    = FETCH;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign imem_req  = w_req;
    assign imem_addr = r_req_addr;
    assign if_valid  = r_if_valid;
    assign if_pc     = r_if_pc;
    assign if_instr  = r_if_instr;

endmodule

// File: tb/tb_elbeth_fetch_ctrl.sv
// tb/tb_elbeth_fetch_ctrl.sv - directed scoreboard bench for elbeth_fetch_ctrl

module tb_elbeth_fetch_ctrl;

    localparam logic [31:0] KEY = 32'h1357_9BDF;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [0:31] redirect_pc;
    logic        ack;
    logic [0:31] imem_rdata;

    logic        imem_req,  imem_req2;
    logic [0:31] imem_addr, imem_addr2;
    logic        if_valid,  if_valid2;
    logic [0:31] if_pc,     if_pc2;
    logic [0:31] if_instr,  if_instr2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_fail = 0;
    int   n_deliv = 0;
    logic prev_valid = 1'b0;

    elbeth_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(ack), .imem_rdata(imem_rdata), .if_valid(if_valid),
        .if_pc(if_pc), .if_instr(if_instr)
    );

    elbeth_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(ack), .imem_rdata(imem_rdata), .if_valid(if_valid2),
        .if_pc(if_pc2), .if_instr(if_instr2)
    );

    // Memory model: word content is a fixed function of its address.
    assign imem_rdata = ack ? (imem_addr ^ KEY) : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc  = pc;
        e.ins = pc ^ KEY;
        exp_q.push_back(e);
    endtask

    task automatic nstep();
        @(negedge clk);
    endtask

    // Each rising edge of if_valid is one delivered instruction; compare against the scoreboard.
    always @(negedge clk) begin
        if (if_valid && !prev_valid) begin
            n_deliv++;
            if (exp_q.size() == 0) begin
                check("unexpected_delivery_pc", if_pc, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("deliv_pc", if_pc, e.pc);
                check("deliv_instr", if_instr, e.ins);
            end
        end
        prev_valid = if_valid;
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; ack = 1'b0;
        repeat (2) nstep();
        check("rst_req", imem_req, 0);
        check("rst_valid", if_valid, 0);
        check("rst_if_pc", if_pc, 0);
        check("rst_if_instr", if_instr, 0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_addr2", imem_addr2, 32'hFFFF_FFFC);

        // Sequential stream, zero wait states.
        rst_n = 1'b1; ack = 1'b1;
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
        nstep();
        check("seq_req0", imem_req, 1);
        check("seq_addr0", imem_addr, 32'h0);
        nstep();
        check("seq_req_deliver", imem_req, 0);
        check("seq_valid0", if_valid, 1);
        check("wrap_if_pc2", if_pc2, 32'hFFFF_FFFC);
        nstep();
        check("seq_addr4", imem_addr, 32'h4);
        check("seq_valid_gap", if_valid, 0);
        check("wrap_addr2", imem_addr2, 32'h0);
        nstep();
        check("seq_pc4", if_pc, 32'h4);
        nstep();
        check("seq_addr8", imem_addr, 32'h8);
        nstep();
        check("seq_valid8", if_valid, 1);

        // Hold in DELIVER for five stalled cycles.
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            nstep();
            check("stall_valid", if_valid, 1);
            check("stall_pc", if_pc, 32'h8);
            check("stall_instr", if_instr, 32'h8 ^ KEY);
            check("stall_req", imem_req, 0);
        end
        stall = 1'b0; ack = 1'b0;
        nstep();
        check("fetch_c_addr", imem_addr, 32'hC);
        check("fetch_c_valid", if_valid, 0);

        // Redirect while the fetch waits three cycles for its ack.
        redirect = 1'b1; redirect_pc = 32'h100;
        nstep();
        redirect = 1'b0;
        check("flush_addr_a", imem_addr, 32'hC);
        check("flush_req_a", imem_req, 1);
        check("flush_valid_a", if_valid, 0);
        nstep();
        check("flush_addr_b", imem_addr, 32'hC);
        ack = 1'b1;
        nstep();
        check("redir_addr", imem_addr, 32'h100);
        check("redir_valid", if_valid, 0);
        push_exp(32'h100);
        nstep();
        check("redir_pc", if_pc, 32'h100);

        // Redirect to an unaligned target together with an ack.
        nstep();
        check("seq_addr104", imem_addr, 32'h104);
        redirect = 1'b1; redirect_pc = 32'h203;
        nstep();
        redirect = 1'b0;
        check("align_addr", imem_addr, 32'h200);
        check("align_valid", if_valid, 0);
        push_exp(32'h200);
        nstep();
        check("align_pc", if_pc, 32'h200);

        // Redirect in DELIVER wins over stall.
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        nstep();
        redirect = 1'b0; stall = 1'b0; ack = 1'b0;
        check("deliv_redir_addr", imem_addr, 32'h40);
        check("deliv_redir_valid", if_valid, 0);
        check("deliv_redir_req", imem_req, 1);

        // Asynchronous reset in the middle of a pending fetch.
        nstep();
        check("pre_rst_req", imem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_req", imem_req, 0);
        check("async_rst_valid", if_valid, 0);
        check("async_rst_addr", imem_addr, 32'h0);
        nstep();
        rst_n = 1'b1; ack = 1'b1; stall = 1'b1;
        push_exp(32'h0);
        nstep();
        check("restart_addr", imem_addr, 32'h0);
        check("restart_req", imem_req, 1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) nstep();
        nstep();
        check("scoreboard_empty", exp_q.size(), 0);
        check("delivery_count", n_deliv, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
